// File: rtl/uart_rx_if.sv
// Byte-side handshake of uart_rx: received byte with valid/ack, status and error flags.
// master = receiver, slave = consumer.
interface uart_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       busy;
  logic       frame_err;
  logic       parity_err;
  logic       overrun;

  modport master (
    output rx_data, rx_valid, busy, frame_err, parity_err, overrun,
    input  rx_ack
  );

  modport slave (
    input  rx_data, rx_valid, busy, frame_err, parity_err, overrun,
    output rx_ack
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 (start/8 data/parity/stop when UART_RX_PARITY_EN is defined); 2-flop sync, mid-bit sampling.
// Byte valid one cycle after the stop sample; a byte completing while rx_valid is held is dropped and sets overrun.
module uart_rx #(
  parameter int CLKS_PER_BIT = 48,
  parameter int PARITY_ODD   = 0
) (
  input  logic      i_clk,
  input  logic      i_rst_n,
  input  logic      i_rx,
  uart_rx_if.master rx_if
);
  localparam int            CW         = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LP_HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LP_LAST    = CW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 8 || (CLKS_PER_BIT % 2) != 0 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx: CLKS_PER_BIT must be even and >= 8, PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        r_state;
  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic [7:0]    r_data;
  logic          r_valid;
  logic          r_busy;
  logic          r_ferr;
  logic          r_ovr;
  logic          w_rx_s;
`ifdef UART_RX_PARITY_EN
  localparam logic LP_ODD = 1'(PARITY_ODD);
  logic          r_perr;
  logic          r_par_bad;
`endif

  assign w_rx_s = r_sync[1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync    <= 2'b11;
      r_state   <= S_WAIT_IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_busy    <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr    <= 1'b0;
      r_par_bad <= 1'b0;
`endif
    end else begin
      r_sync <= {r_sync[0], i_rx};
      r_ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_perr <= 1'b0;
`endif
      // Consumer ack; a delivery in the same cycle below overrides the clear of r_valid.
      if (r_valid && rx_if.rx_ack) begin
        r_valid <= 1'b0;
        r_ovr   <= 1'b0;
      end

      case (r_state)
        S_WAIT_IDLE: begin
          r_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
            r_busy  <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == LP_HALF_M1) begin
            r_cnt <= '0;
            if (!w_rx_s) begin
              r_state <= S_DATA;
              r_idx   <= '0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (r_cnt == LP_LAST) begin
            r_cnt          <= '0;
            r_shift[r_idx] <= w_rx_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              r_state <= S_PARITY;
`else
              r_state <= S_STOP;
`endif
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (r_cnt == LP_LAST) begin
            r_cnt     <= '0;
            r_par_bad <= (w_rx_s != ((^r_shift) ^ LP_ODD));
            r_state   <= S_STOP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
`endif
        S_STOP: begin
          if (r_cnt == LP_LAST) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            if (w_rx_s) begin
              r_state <= S_IDLE;
`ifdef UART_RX_PARITY_EN
              if (r_par_bad) begin
                r_perr <= 1'b1;
              end else
`endif
              if (!r_valid || rx_if.rx_ack) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_ovr <= 1'b1;
              end
            end else begin
              // Stop bit low: treat as break, wait for the line to return high.
              r_ferr  <= 1'b1;
              r_state <= S_WAIT_IDLE;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_WAIT_IDLE;
          r_busy  <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign rx_if.rx_data   = r_data;
  assign rx_if.rx_valid  = r_valid;
  assign rx_if.busy      = r_busy;
  assign rx_if.frame_err = r_ferr;
  assign rx_if.overrun   = r_ovr;
`ifdef UART_RX_PARITY_EN
  assign rx_if.parity_err = r_perr;
`else
  assign rx_if.parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frames, a frame-level expectation model and per-cycle output compare.
module tb_uart_rx;
  localparam int CPB   = 48;
  localparam int HALF  = CPB / 2;
  localparam int P_ODD = 0;
`ifdef UART_RX_PARITY_EN
  localparam int NB       = 11;
  localparam int LIT_RISE = 506;
`else
  localparam int NB       = 10;
  localparam int LIT_RISE = 458;
`endif
  localparam int EV_DELIVER = 0;
  localparam int EV_FERR    = 1;
  localparam int EV_PERR    = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  uart_rx_if u_if ();

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(P_ODD)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_rx    (rx),
    .rx_if   (u_if.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp_v);
    end
  endtask

  // Frame-level model: each frame schedules a busy window and one outcome event.
  bit         m_valid = 1'b0;
  bit         m_ovr   = 1'b0;
  bit         m_ferr  = 1'b0;
  bit         m_perr  = 1'b0;
  logic [7:0] m_data  = 8'h00;
  int         ev_cyc[$];
  int         ev_kind[$];
  logic [7:0] ev_dat[$];
  int         bw_lo[$];
  int         bw_hi[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_perr = 1'b0; m_data = 8'h00;
      ev_cyc.delete(); ev_kind.delete(); ev_dat.delete();
      bw_lo.delete(); bw_hi.delete();
    end else begin
      bit old_v;
      bit ack;
      cyc++;
      m_ferr = 1'b0;
      m_perr = 1'b0;
      old_v  = m_valid;
      ack    = u_if.rx_ack;
      if (old_v && ack) begin m_valid = 1'b0; m_ovr = 1'b0; end
      while (ev_cyc.size() > 0 && ev_cyc[0] == cyc) begin
        int         kd;
        logic [7:0] dd;
        kd = ev_kind.pop_front(); dd = ev_dat.pop_front(); void'(ev_cyc.pop_front());
        if (kd == EV_DELIVER) begin
          if (!old_v || ack) begin m_data = dd; m_valid = 1'b1; end
          else m_ovr = 1'b1;
        end else if (kd == EV_FERR) m_ferr = 1'b1;
        else m_perr = 1'b1;
      end
    end
  end

  int ferr_cnt = 0, perr_cnt = 0, last_rise = -1, last_bfall = -1;
  bit prev_valid = 1'b0, prev_busy = 1'b0;

  always @(negedge clk) begin
    bit exp_busy;
    exp_busy = 1'b0;
    foreach (bw_lo[i]) if (cyc >= bw_lo[i] && cyc <= bw_hi[i]) exp_busy = 1'b1;
    chk("rx_valid",   u_if.rx_valid,   m_valid);
    chk("rx_data",    u_if.rx_data,    m_data);
    chk("overrun",    u_if.overrun,    m_ovr);
    chk("frame_err",  u_if.frame_err,  m_ferr);
    chk("parity_err", u_if.parity_err, m_perr);
    chk("busy",       u_if.busy,       exp_busy);
    if (u_if.rx_valid === 1'b1 && !prev_valid) last_rise = cyc;
    if (u_if.busy === 1'b0 && prev_busy) last_bfall = cyc;
    if (u_if.frame_err === 1'b1) ferr_cnt++;
    if (u_if.parity_err === 1'b1) perr_cnt++;
    prev_valid = (u_if.rx_valid === 1'b1);
    prev_busy  = (u_if.busy === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    u_if.rx_ack = 1'b1;
    tick(1);
    u_if.rx_ack = 1'b0;
  endtask

  // Drives one frame; stop_low>0 holds the stop bit low for that many bit times; abort_at>0 resets mid-frame.
  task automatic send_frame(input logic [7:0] d, input bit par_ok, input int stop_low,
                            input int abort_at, output int t0);
    logic slot[16];
    int   ns, stop_cyc, kind, n;
    ns = 0;
    slot[ns++] = 1'b0;
    for (int i = 0; i < 8; i++) slot[ns++] = d[i];
`ifdef UART_RX_PARITY_EN
    slot[ns++] = ((^d) ^ (P_ODD != 0)) ^ !par_ok;
`endif
    if (stop_low > 0) for (int i = 0; i < stop_low; i++) slot[ns++] = 1'b0;
    else slot[ns++] = 1'b1;
    t0       = cyc + 1;
    stop_cyc = t0 + 1 + HALF + (NB - 1) * CPB;
    kind     = (stop_low > 0) ? EV_FERR : (!par_ok ? EV_PERR : EV_DELIVER);
    bw_lo.push_back(t0 + 2); bw_hi.push_back(stop_cyc);
    ev_cyc.push_back(stop_cyc + 1); ev_kind.push_back(kind); ev_dat.push_back(d);
    n = 0;
    for (int s = 0; s < ns; s++) begin
      for (int c = 0; c < CPB; c++) begin
        rx = slot[s];
        if (abort_at > 0 && n == abort_at) begin
          rst_n = 1'b0;
          rx    = 1'b1;
          return;
        end
        n++;
        tick(1);
      end
    end
    rx = 1'b1;
  endtask

  initial begin
    int t0;
    u_if.rx_ack = 1'b0;
    tick(3);
    chk("reset_valid", u_if.rx_valid, 1'b0);
    chk("reset_busy",  u_if.busy,     1'b0);
    rst_n = 1'b1;
    tick(5);

    // 0xA5, no ack
    send_frame(8'hA5, 1'b1, 0, 0, t0);
    tick(3);
    chk("a5_rise_time", last_rise - t0,  LIT_RISE);
    chk("a5_busy_fall", last_bfall - t0, LIT_RISE);
    chk("a5_data",      u_if.rx_data,    8'hA5);
    chk("a5_no_ferr",   ferr_cnt,        0);
    ack_pulse();
    tick(2);
    chk("a5_acked", u_if.rx_valid, 1'b0);

    // Back-to-back without ack: second byte dropped
    send_frame(8'h3C, 1'b1, 0, 0, t0);
    send_frame(8'hC3, 1'b1, 0, 0, t0);
    tick(3);
    chk("b2b_data",    u_if.rx_data, 8'h3C);
    chk("b2b_overrun", u_if.overrun, 1'b1);
    ack_pulse();
    tick(1);
    chk("b2b_ack_valid", u_if.rx_valid, 1'b0);
    chk("b2b_ack_ovr",   u_if.overrun,  1'b0);

    // 10-cycle low glitch on the line
    t0 = cyc + 1;
    bw_lo.push_back(t0 + 2); bw_hi.push_back(t0 + 1 + HALF);
    rx = 1'b0;
    tick(10);
    rx = 1'b1;
    tick(60);
    chk("glitch_busy",  u_if.busy,     1'b0);
    chk("glitch_valid", u_if.rx_valid, 1'b0);

    // Framing error (stop low for two bit times), then recovery
    send_frame(8'h55, 1'b1, 2, 0, t0);
    tick(20);
    chk("ferr_count", ferr_cnt,       1);
    chk("ferr_valid", u_if.rx_valid,  1'b0);
    send_frame(8'h12, 1'b1, 0, 0, t0);
    tick(3);
    chk("after_ferr_data", u_if.rx_data, 8'h12);
    ack_pulse();

    // Reset during data bit 4
    send_frame(8'h5A, 1'b1, 0, 5 * CPB + 10, t0);
    tick(2);
    chk("rst_data",  u_if.rx_data,  8'h00);
    chk("rst_busy",  u_if.busy,     1'b0);
    chk("rst_valid", u_if.rx_valid, 1'b0);
    rst_n = 1'b1;
    tick(5);
    send_frame(8'h81, 1'b1, 0, 0, t0);
    tick(3);
    chk("post_rst_data", u_if.rx_data, 8'h81);
    ack_pulse();

`ifdef UART_RX_PARITY_EN
    send_frame(8'h07, 1'b0, 0, 0, t0);
    tick(3);
    chk("perr_count", perr_cnt,      1);
    chk("perr_valid", u_if.rx_valid, 1'b0);
    send_frame(8'h07, 1'b1, 0, 0, t0);
    tick(3);
    chk("par_ok_data", u_if.rx_data, 8'h07);
    ack_pulse();
`endif
    tick(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=timeout required=finish", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
